// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// Optional result clamping is enabled with SERIAL_ADD_SUB_SATURATE_EN.
package serial_add_sub_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // One spare bit so the counter can hold the digit count itself.
   function automatic int cnt_width(input int width, input int digit);
      return $clog2(width / digit) + 1;
   endfunction

endpackage

// File: rtl/serial_add_sub_addsub_digit.sv
// Combinational DIGIT-bit slice: a short ripple of carry cells (add) or
// borrow cells (sub) sharing one chain input and one chain output.
module addsub_digit
   import serial_add_sub_pkg::*;
#(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             mode,
   input  logic             cb_in,
   output logic [DIGIT-1:0] s_d,
   output logic             cb_out_d
);

   logic [DIGIT:0] chain;

   always_comb begin
      chain    = '0;
      s_d      = '0;
      chain[0] = cb_in;
      for (int i = 0; i < DIGIT; i++) begin
         s_d[i] = a_d[i] ^ b_d[i] ^ chain[i];
         if (mode == MODE_SUB) begin
            chain[i+1] = (~a_d[i] & b_d[i]) | (~(a_d[i] ^ b_d[i]) & chain[i]);
         end else begin
            chain[i+1] = (a_d[i] & b_d[i]) | ((a_d[i] ^ b_d[i]) & chain[i]);
         end
      end
   end

   assign cb_out_d = chain[DIGIT];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor with start/busy/done handshake, LSB digit first.
// Define SERIAL_ADD_SUB_SATURATE_EN to clamp overflowing results to the signed extremes.
module serial_add_sub
   import serial_add_sub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cb_out,
   output logic             overflow
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = cnt_width(WIDTH, DIGIT);
   localparam int PW   = (DIGIT < WIDTH) ? (WIDTH - DIGIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_add_sub: WIDTH must be >= 2 and an exact multiple of DIGIT");
   end

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic             mode_q, mode_d;
   logic             chain_q, chain_d;
   logic [PW-1:0]    part_q, part_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cb_q, cb_d;
   logic             ovf_q, ovf_d;

   logic [DIGIT-1:0] slice_s;
   logic             slice_cb;
   logic [WIDTH-1:0] full_res;
   logic [PW-1:0]    part_shift;
   logic             sign_a, sign_b, sign_r, ovf_now;

   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .a_d      (opa_q[DIGIT-1:0]),
      .b_d      (opb_q[DIGIT-1:0]),
      .mode     (mode_q),
      .cb_in    (chain_q),
      .s_d      (slice_s),
      .cb_out_d (slice_cb)
   );

   // New digits enter at the MSB end; on the last digit full_res is the whole answer.
   if (DIGIT < WIDTH) begin : g_part
      assign full_res   = {slice_s, part_q};
      assign part_shift = full_res[WIDTH-1:DIGIT];
   end else begin : g_nopart
      assign full_res   = slice_s;
      assign part_shift = part_q;
   end

   // On the final digit the operand registers still hold the original sign bits.
   assign sign_a  = opa_q[DIGIT-1];
   assign sign_b  = opb_q[DIGIT-1];
   assign sign_r  = slice_s[DIGIT-1];
   assign ovf_now = (mode_q == MODE_SUB) ? ((sign_a != sign_b) && (sign_r != sign_a))
                                         : ((sign_a == sign_b) && (sign_r != sign_a));

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      mode_d   = mode_q;
      chain_d  = chain_q;
      part_d   = part_q;
      result_d = result_q;
      cb_d     = cb_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               opa_d   = a;
               opb_d   = b;
               mode_d  = mode;
               chain_d = 1'b0;
               count_d = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            opa_d   = opa_q >> DIGIT;
            opb_d   = opb_q >> DIGIT;
            chain_d = slice_cb;
            part_d  = part_shift;
            count_d = count_q + 1'b1;
            if (count_q == LAST) begin
               state_d  = DONE;
               result_d = full_res;
               cb_d     = slice_cb;
               ovf_d    = ovf_now;
`ifdef SERIAL_ADD_SUB_SATURATE_EN
               // A positive operand A means the true result overflowed upwards.
               if (ovf_now) begin
                  result_d = sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         mode_q   <= MODE_ADD;
         chain_q  <= 1'b0;
         part_q   <= '0;
         result_q <= '0;
         cb_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         mode_q   <= mode_d;
         chain_q  <= chain_d;
         part_q   <= part_d;
         result_q <= result_d;
         cb_q     <= cb_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);
   assign result   = result_q;
   assign cb_out   = cb_q;
   assign overflow = ovf_q;

endmodule
